// File: rtl/hvac_sequencer.sv
// Climate actuator sequencer: threshold/hysteresis heating and cooling with minimum on-time,
// post-run dead-time, and exclusive arbitration of the shared supply with the blinds motor.
module hvac_sequencer #(
    parameter int unsigned T_LOW  = 18,
    parameter int unsigned T_HIGH = 22,
    parameter int unsigned HYST   = 1,
    parameter int unsigned MIN_ON = 16,
    parameter int unsigned DEAD   = 8,
    parameter int unsigned CW     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] temperature,
    input  logic       blind_req,
    output logic       blind_gnt,
    output logic       heating,
    output logic       cooling,
    output logic [1:0] state,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeat = 2'd1,
        StCool = 2'd2,
        StDead = 2'd3
    } state_e;

    localparam logic [4:0]    TempLow  = 5'(T_LOW);
    localparam logic [4:0]    TempHigh = 5'(T_HIGH);
    localparam logic [4:0]    HeatOff  = 5'(T_LOW + HYST);
    localparam logic [4:0]    CoolOff  = 5'(T_HIGH - HYST);
    localparam logic [CW-1:0] MinOnTc  = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] DeadTc   = CW'(DEAD - 1);
    localparam logic [CW-1:0] TimerMax = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          gnt_q, gnt_d;
    logic          heating_q, cooling_q, busy_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Blinds own the supply until their grant has been seen low for a cycle
                if (blind_req || gnt_q) begin
                    gnt_d = blind_req;
                end else if (enable && (temperature < TempLow)) begin
                    state_d = StHeat;
                end else if (enable && (temperature > TempHigh)) begin
                    state_d = StCool;
                end
            end
            StHeat: begin
                if (!enable || ((timer_q >= MinOnTc) && (temperature >= HeatOff))) begin
                    state_d = StDead;
                end
            end
            StCool: begin
                if (!enable || ((timer_q >= MinOnTc) && (temperature <= CoolOff))) begin
                    state_d = StDead;
                end
            end
            StDead: begin
                // A pending blinds request is granted on the very first IDLE cycle
                if (timer_q >= DeadTc) begin
                    state_d = StIdle;
                    gnt_d   = blind_req;
                end
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TimerMax) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            gnt_q     <= 1'b0;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            heating_q <= (state_d == StHeat);
            cooling_q <= (state_d == StCool);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign state     = state_q;
    assign blind_gnt = gnt_q;
    assign heating   = heating_q;
    assign cooling   = cooling_q;
    assign busy      = busy_q;

endmodule
